mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Initiator side of the data-memory interface. It sits in the MEM stage of the pipeline and turns a stage-level load/store request into the word-indexed mem_read/mem_write/address/data handshake the data memory responds to. It holds each access for a fixed number of cycles and returns the load result. While an access is in flight it asserts freeze to stall the pipeline.

Parameters:
ADDR_BASE, 1024, byte address that maps to memory word 0
LATENCY, 2, cycles each access is held on the memory interface (legal range 1..15)
WORD_AW, 6, memory word-address width (64 words)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_rd  in  1  MEM-stage load request
req_wr  in  1  MEM-stage store request
req_addr  in  32  byte address from ALU
req_wdata  in  32  store data
freeze  out  1  pipeline stall while access pending
rd_data  out  32  load result, held until next load completes
rd_valid  out  1  one-cycle pulse when rd_data updated
mem_read  out  1  to memory: read enable
mem_write  out  1  to memory: write enable
mem_address  out  WORD_AW  to memory: word index
mem_data  out  32  to memory: write data
mem_result  in  32  from memory: read data (combinational, valid while mem_read high)

Behaviour:
- Reset (async): state=IDLE, cnt=0, rd_data=0, rd_valid=0, mem_read=0, mem_write=0, mem_address=0, mem_data=0.
- Address translation: mem_address = ((req_addr - ADDR_BASE) >> 2)[WORD_AW-1:0]. Address and write data are latched at request acceptance and are not re-sampled during the access.
- FSM states IDLE, ACCESS, DONE.
- IDLE:
  - If req_rd|req_wr: latch op/address/data, cnt=0, go to ACCESS.
  - If both req_rd and req_wr: the store wins and the load is dropped; no rd_valid.
- ACCESS:
  - Load: mem_read=1 for all LATENCY cycles.
  - Store: mem_write=1 only in the first ACCESS cycle (single write edge), 0 afterwards.
  - cnt increments each cycle.
  - At the edge ending the cycle with cnt==LATENCY-1: on a load, capture mem_result into rd_data and set rd_valid=1; go to DONE.
- DONE: mem_read=mem_write=0, rd_valid high this cycle only (load), freeze=0. Any request seen here is ignored because it is the same instruction. Go to IDLE unconditionally.
- freeze (combinational) = (IDLE & (req_rd|req_wr)) | ACCESS. Freeze therefore lasts exactly 1+LATENCY cycles per access; DONE releases the pipeline.
- No request in IDLE: all memory strobes 0 and freeze 0. Steady IDLE with no request is a legal indefinite state.
- Back-to-back accesses: the next request is accepted in the IDLE cycle following DONE. Minimum spacing is 2+LATENCY cycles per access.
- Reset mid-access: abort immediately. Strobes drop in the same cycle, any pending write is lost if its edge has not yet occurred, and rd_data=0.
- mem_data = latched req_wdata during a store, 0 otherwise.

Optional Feature:
MEM_RANGE_CHECK_EN
- Defined:
  - Adds output err (1 bit, reset 0).
  - A request whose req_addr[1:0]!=0, or whose address lies outside [ADDR_BASE, ADDR_BASE+4*2^WORD_AW), performs no memory access: mem_read and mem_write stay 0 for the whole access.
  - The FSM still walks IDLE→ACCESS→DONE with the same timing.
  - In DONE, err pulses 1 for one cycle. A faulting load sets rd_data=0 with rd_valid=1.
- Undefined: no err port. Addresses are truncated/wrapped modulo 2^WORD_AW words and low bits are dropped silently.

Test Plan:
- Load, LATENCY=2, memory freshly reset (word i holds i): req_rd, req_addr=1044 → mem_address=5, mem_read high 2 cycles, freeze high 3 cycles, rd_data=5, rd_valid pulse in DONE.
- Store then load: req_wr addr=1032, wdata=0xDEADBEEF → single mem_write cycle at mem_address=2. Next req_rd addr=1032 → rd_data=0xDEADBEEF.
- Simultaneous req_rd=req_wr=1, addr=1028, wdata=0x12345678 → store performed at word 1, no rd_valid, rd_data unchanged. A subsequent load at 1028 returns 0x12345678.
- Reset asserted in the 1st ACCESS cycle of a load at 1060 → freeze, mem_read and rd_data go 0 immediately. After release, state IDLE and the next load at 1060 returns 9.
- Back-to-back loads at 1024 and 1028 held on req lines → two separate accesses, rd_data 0 then 1, second freeze starts the cycle after the first DONE.
- With MEM_RANGE_CHECK_EN: load at 1026 and store at 1280 → no mem_read/mem_write, err pulse each, the load gives rd_data=0. Without the macro: a load at 1280 reads word 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : MEM-stage initiator for the word-indexed data memory; holds each
//           access for LATENCY cycles and stalls the pipeline meanwhile.
//           Optional macro MEM_RANGE_CHECK_EN adds alignment/range faulting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int ADDR_BASE = 1024,
  parameter int LATENCY   = 2,
  parameter int WORD_AW   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_rd,
  input  logic               req_wr,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               freeze,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WORD_AW-1:0] mem_address,
  output logic [31:0]        mem_data,
`ifdef MEM_RANGE_CHECK_EN
  output logic               err,
`endif
  input  logic [31:0]        mem_result
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] BASE_W   = 32'(ADDR_BASE);
  localparam logic [3:0]  LAST_CNT = 4'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic                 fault_q, fault_d;
  logic [WORD_AW-1:0]   addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
`ifdef MEM_RANGE_CHECK_EN
  logic                 err_q, err_d;
`endif

  logic [31:0]          w_off;
  logic [WORD_AW-1:0]   w_widx;
  logic                 w_fault;

  assign w_off  = req_addr - BASE_W;
  assign w_widx = w_off[WORD_AW+1:2];

`ifdef MEM_RANGE_CHECK_EN
  // Below-base addresses show up as an unsigned compare; above-range as high offset bits.
  assign w_fault = (req_addr[1:0] != 2'b00) || (req_addr < BASE_W) ||
                   (w_off[31:WORD_AW+2] != '0);
`else
  assign w_fault = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    fault_d    = fault_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    err_d      = 1'b0;
`endif
    freeze     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_data   = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (req_rd || req_wr) begin
          freeze  = 1'b1;
          state_d = S_ACCESS;
          cnt_d   = 4'd0;
          // A combined request is treated as a store; the load half is dropped.
          wr_d    = req_wr;
          fault_d = w_fault;
          addr_d  = w_widx;
          wdata_d = req_wdata;
        end
      end
      S_ACCESS: begin
        freeze    = 1'b1;
        mem_read  = !wr_q && !fault_q;
        mem_write = wr_q && !fault_q && (cnt_q == 4'd0);
        mem_data  = (wr_q && !fault_q) ? wdata_q : 32'd0;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          if (!wr_q) begin
            rd_data_d  = fault_q ? 32'd0 : mem_result;
            rd_valid_d = 1'b1;
          end
`ifdef MEM_RANGE_CHECK_EN
          err_d = fault_q;
`endif
        end
      end
      S_DONE: begin
        // Request lines still carry the same instruction here; ignore them.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      fault_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      fault_q    <= fault_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef MEM_RANGE_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign mem_address = addr_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
`ifdef MEM_RANGE_CHECK_EN
  assign err         = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Table-driven bench for mem_access_ctrl with a 64-word memory model
//           (word i preloaded with i). Honours MEM_RANGE_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam int LAT = 2;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_rd, req_wr;
  logic [31:0]   req_addr, req_wdata;
  logic          freeze, rd_valid, mem_read, mem_write;
  logic [31:0]   rd_data, mem_data, mem_result;
  logic [AW-1:0] mem_address;
`ifdef MEM_RANGE_CHECK_EN
  logic          err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl #(.ADDR_BASE(1024), .LATENCY(LAT), .WORD_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .freeze      (freeze),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_data    (mem_data),
`ifdef MEM_RANGE_CHECK_EN
    .err         (err),
`endif
    .mem_result  (mem_result)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'(i);
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_data;
  assign mem_result = mem[mem_address];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  widx;
    logic        fault;
    logic        exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic er, ew;
    @(negedge clk);
    req_rd = v.rd; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    #1;
    chk("idle_freeze", 32'(freeze), 32'd1);
    chk("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk); #1;
      er = v.rd && !v.wr && !v.fault;
      ew = v.wr && !v.fault && (k == 1);
      chk("acc_freeze", 32'(freeze), 32'd1);
      chk("acc_mem_read", 32'(mem_read), 32'(er));
      chk("acc_mem_write", 32'(mem_write), 32'(ew));
      chk("acc_rd_valid", 32'(rd_valid), 32'd0);
      if (!v.fault) chk("acc_mem_address", 32'(mem_address), 32'(v.widx));
      if (ew) chk("acc_mem_data", mem_data, v.wdata);
    end
    @(negedge clk); #1;
    chk("done_freeze", 32'(freeze), 32'd0);
    chk("done_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("done_rd_valid", 32'(rd_valid), 32'(v.exp_valid));
    chk("done_rd_data", rd_data, v.exp_rdata);
`ifdef MEM_RANGE_CHECK_EN
    chk("done_err", 32'(err), 32'(v.fault));
`endif
  endtask

  initial begin
    //              rd    wr    addr  wdata         widx  flt   vld   rdata
    vecs.push_back('{1'b1, 1'b0, 1044, 32'h0,        6'd5, 1'b0, 1'b1, 32'd5});
    vecs.push_back('{1'b1, 1'b0, 1024, 32'h0,        6'd0, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b1, 1'b0, 1028, 32'h0,        6'd1, 1'b0, 1'b1, 32'd1});
    vecs.push_back('{1'b0, 1'b1, 1032, 32'hDEADBEEF, 6'd2, 1'b0, 1'b0, 32'd1});
    vecs.push_back('{1'b1, 1'b0, 1032, 32'h0,        6'd2, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b1, 1028, 32'h12345678, 6'd1, 1'b0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 1028, 32'h0,        6'd1, 1'b0, 1'b1, 32'h12345678});
`ifdef MEM_RANGE_CHECK_EN
    vecs.push_back('{1'b1, 1'b0, 1026, 32'h0,        6'd0, 1'b1, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1280, 32'hCAFEF00D, 6'd0, 1'b1, 1'b0, 32'd0});
`else
    vecs.push_back('{1'b1, 1'b0, 1280, 32'h0,        6'd0, 1'b0, 1'b1, 32'd0});
`endif

    rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    rst = 1'b0;

    // Request lines stay asserted through DONE, so successive vectors are back-to-back.
    foreach (vecs[i]) run_vec(vecs[i]);

    @(negedge clk);
    req_rd = 1'b0; req_wr = 1'b0;
    #1;
    chk("idle_noreq_freeze", 32'(freeze), 32'd0);
    chk("idle_noreq_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk); #1;
    chk("idle_hold_freeze", 32'(freeze), 32'd0);

    // Abort a load at 1060 in its first ACCESS cycle; rd_data currently nonzero.
    @(negedge clk);
    run_vec('{1'b1, 1'b0, 1028, 32'h0, 6'd1, 1'b0, 1'b1, 32'h12345678});
    @(negedge clk);
    req_rd = 1'b1; req_addr = 1060;
    @(negedge clk); #1;
    chk("abort_pre_read", 32'(mem_read), 32'd1);
    chk("abort_pre_addr", 32'(mem_address), 32'd9);
    rst = 1'b1; req_rd = 1'b0;
    #1;
    chk("abort_freeze", 32'(freeze), 32'd0);
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_abort_freeze", 32'(freeze), 32'd0);
    chk("post_abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    run_vec('{1'b1, 1'b0, 1060, 32'h0, 6'd9, 1'b0, 1'b1, 32'd9});

    @(negedge clk);
    req_rd = 1'b0; req_wr = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
